// File: rtl/pu_ex_md.sv
// Iterative multiply/divide sequencer for the EX stage: shift-add multiply and restoring
// divide on operand magnitudes, one iteration per cycle, with a combinational stall request.
module pu_ex_md #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              divz_q, divz_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] hi_q, lo_q;

  logic              op_valid, op_signed, op_div, start;
  logic              neg0, neg1;
  logic [DATA_W-1:0] mag0, mag1;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] prod_mag, prod;
  logic [DATA_W-1:0] res_hi, res_lo;

  assign op_valid  = (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  assign op_signed = (op == OpMult) || (op == OpDiv);
  assign op_div    = (op == OpDiv) || (op == OpDivu);
  assign start     = (state_q == StIdle) && en && op_valid && !flush;

  assign neg0 = op_signed && in0[DATA_W-1];
  assign neg1 = op_signed && in1[DATA_W-1];
  assign mag0 = neg0 ? -in0 : in0;
  assign mag1 = neg1 ? -in1 : in1;

  // Multiply step: conditionally add the multiplicand, then shift {acc_hi, acc_lo} right.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : '0);
  // Divide step: shift the next dividend bit into the remainder and trial-subtract.
  assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opa_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    divz_d   = divz_q;
    opa_d    = opa_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCalc;
          cnt_d    = '0;
          is_div_d = op_div;
          neg_a_d  = neg0;
          neg_b_d  = neg1;
          divz_d   = (in1 == '0);
          acc_hi_d = '0;
          // Multiply keeps the multiplier in acc_lo; divide keeps the dividend there.
          opa_d    = op_div ? mag1 : mag0;
          acc_lo_d = op_div ? mag0 : mag1;
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = StDone;
          if (is_div_q) begin
            if (!div_diff[DATA_W]) begin
              acc_hi_d = div_diff[DATA_W-1:0];
              acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b1};
            end else begin
              acc_hi_d = div_shift[DATA_W-1:0];
              acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b0};
            end
          end else begin
            acc_hi_d = mul_sum[DATA_W:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sign fix-up; a zero divisor yields all-ones quotient and the raw dividend as remainder.
  assign prod_mag = {acc_hi_q, acc_lo_q};
  assign prod     = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;

  always_comb begin
    res_hi = prod[2*DATA_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (is_div_q) begin
      res_hi = neg_a_q ? -acc_hi_q : acc_hi_q;
      if (divz_q)                 res_lo = '1;
      else if (neg_a_q ^ neg_b_q) res_lo = -acc_lo_q;
      else                        res_lo = acc_lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      divz_q   <= 1'b0;
      opa_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      divz_q   <= divz_d;
      opa_q    <= opa_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      if (state_q == StDone) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign busy = ((state_q == StIdle && start) || state_q == StCalc) && !flush && !rst;
  assign done = (state_q == StDone);
  assign hi   = done ? res_hi : hi_q;
  assign lo   = done ? res_lo : lo_q;

endmodule
